// File: rtl/bcd_scan_mux_pkg.sv
// Shared display definitions: scan states, digit-index sizing and the
// enable-polarity helper used by the display drivers.
package bcd_scan_mux_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Digit-index width; a single digit still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n_digits);
    return (n_digits > 32'd1) ? $clog2(n_digits) : 32'd1;
  endfunction

  // Maps a logical enable onto the physical driver level.
  function automatic logic en_level(input logic enable, input logic active_low);
    return enable ^ active_low;
  endfunction

endpackage

// File: rtl/bcd_scan_mux_slot_timer.sv
// Digit-slot timer: free-running 0..CLK_DIV-1 counter with strobes on the
// last blanking cycle and the last cycle of the slot.
module bcd_scan_mux_slot_timer #(
  parameter int unsigned CLK_DIV      = 12000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_slot_wrap,
  output logic o_blank_end
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLK_DIV - 32'd1);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 32'd1);

  logic [CNT_W-1:0] cnt_r;
  logic             slot_wrap_s;
  logic             blank_end_s;

  // Strobe decode from the counter value of the current cycle.
  always_comb begin
    slot_wrap_s = (cnt_r == CNT_LAST);
    blank_end_s = (cnt_r == CNT_BLANK_END);
  end

  // Slot counter with wrap at CLK_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (slot_wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign o_slot_wrap = slot_wrap_s;
  assign o_blank_end = blank_end_s;

endmodule

// File: rtl/bcd_scan_mux.sv
// Multiplexed 7-segment digit scanner: double-buffered BCD/DP store, one digit
// per slot, leading blanking window and frame-start pulse. All outputs registered.
module bcd_scan_mux
  import bcd_scan_mux_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned CLK_DIV       = 12000,
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter bit          EN_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*N_DIGITS-1:0] i_digits,
  input  logic [N_DIGITS-1:0]   i_dps,
  input  logic                  i_load,
  input  logic                  i_blank,
  output logic [3:0]            o_bcd,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_digit,
  output logic                  o_frame
);

  localparam int unsigned IDX_W = idx_width(N_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 32'd1);
  localparam logic [N_DIGITS-1:0] EN_OFF   = {N_DIGITS{EN_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic                  slot_wrap_s;
  logic                  blank_end_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_next_s;
  scan_state_e           state_r;
  scan_state_e           state_next_s;
  logic [4*N_DIGITS-1:0] shadow_dig_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [4*N_DIGITS-1:0] active_dig_r;
  logic [N_DIGITS-1:0]   active_dp_r;
  logic [4*N_DIGITS-1:0] active_dig_next_s;
  logic [N_DIGITS-1:0]   active_dp_next_s;
  logic                  pending_r;
  logic                  pending_next_s;
  logic                  frame_start_s;
  logic                  commit_s;
  logic [N_DIGITS-1:0]   en_onehot_s;
  logic [N_DIGITS-1:0]   digit_next_s;
  logic [3:0]            bcd_sel_s;
  logic                  dp_sel_s;
  logic [3:0]            bcd_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   digit_r;
  logic                  frame_r;

  bcd_scan_mux_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_slot_wrap (slot_wrap_s),
    .o_blank_end (blank_end_s)
  );

  // Next-state, buffer commit and next-output decode.
  always_comb begin
    frame_start_s     = slot_wrap_s && (idx_r == IDX_LAST);
    commit_s          = frame_start_s && pending_r;
    idx_next_s        = idx_r;
    state_next_s      = state_r;
    active_dig_next_s = active_dig_r;
    active_dp_next_s  = active_dp_r;
    pending_next_s    = pending_r;
    en_onehot_s       = {N_DIGITS{1'b0}};
    digit_next_s      = EN_OFF;

    if (slot_wrap_s) begin
      if (idx_r == IDX_LAST) begin
        idx_next_s = {IDX_W{1'b0}};
      end else begin
        idx_next_s = idx_r + IDX_W'(1);
      end
    end else begin
      idx_next_s = idx_r;
    end

    case (state_r)
      ST_BLANK: begin
        if (blank_end_s) begin
          state_next_s = ST_SHOW;
        end else begin
          state_next_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (slot_wrap_s) begin
          state_next_s = ST_BLANK;
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      default: state_next_s = ST_BLANK;
    endcase

    // Commit takes the shadow as it was before this edge; a coincident load
    // refills the shadow and keeps pending set for the following frame.
    if (commit_s) begin
      active_dig_next_s = shadow_dig_r;
      active_dp_next_s  = shadow_dp_r;
    end else begin
      active_dig_next_s = active_dig_r;
      active_dp_next_s  = active_dp_r;
    end

    if (i_load) begin
      pending_next_s = 1'b1;
    end else if (commit_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end

    if ((state_next_s == ST_SHOW) && !i_blank) begin
      en_onehot_s = ONE_HOT0 << idx_next_s;
    end else begin
      en_onehot_s = {N_DIGITS{1'b0}};
    end

    for (int k = 0; k < int'(N_DIGITS); k++) begin
      digit_next_s[k] = en_level(en_onehot_s[k], EN_ACTIVE_LOW);
    end

    // Selecting from the next active buffer bypasses it on the commit edge.
    bcd_sel_s = active_dig_next_s[{idx_next_s, 2'b00} +: 4];
    dp_sel_s  = active_dp_next_s[idx_next_s];
  end

  // Scan state, buffers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_r        <= {IDX_W{1'b0}};
      state_r      <= ST_BLANK;
      shadow_dig_r <= {(4*N_DIGITS){1'b0}};
      shadow_dp_r  <= {N_DIGITS{1'b0}};
      active_dig_r <= {(4*N_DIGITS){1'b0}};
      active_dp_r  <= {N_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      bcd_r        <= 4'd0;
      dp_r         <= 1'b0;
      digit_r      <= EN_OFF;
      frame_r      <= 1'b0;
    end else begin
      idx_r        <= idx_next_s;
      state_r      <= state_next_s;
      active_dig_r <= active_dig_next_s;
      active_dp_r  <= active_dp_next_s;
      pending_r    <= pending_next_s;
      if (i_load) begin
        shadow_dig_r <= i_digits;
        shadow_dp_r  <= i_dps;
      end else begin
        shadow_dig_r <= shadow_dig_r;
        shadow_dp_r  <= shadow_dp_r;
      end
      bcd_r        <= bcd_sel_s;
      dp_r         <= dp_sel_s;
      digit_r      <= digit_next_s;
      frame_r      <= frame_start_s;
    end
  end

  assign o_bcd   = bcd_r;
  assign o_dp    = dp_r;
  assign o_digit = digit_r;
  assign o_frame = frame_r;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux with N_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2,
// active-high enables; every cycle is checked against hand-derived slot timing.
module tb_bcd_scan_mux;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_digits;
  logic [3:0]  i_dps;
  logic        i_load;
  logic        i_blank;
  logic [3:0]  o_bcd;
  logic        o_dp;
  logic [3:0]  o_digit;
  logic        o_frame;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int blank_lo = 0;
  int blank_hi = -1;
  bit stim_en  = 1'b1;

  bcd_scan_mux #(
    .N_DIGITS      (4),
    .CLK_DIV       (8),
    .BLANK_CYCLES  (2),
    .EN_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_digits (i_digits),
    .i_dps    (i_dps),
    .i_load   (i_load),
    .i_blank  (i_blank),
    .o_bcd    (o_bcd),
    .o_dp     (o_dp),
    .o_digit  (o_digit),
    .o_frame  (o_frame)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    t++;
  endtask

  // Expected outputs at cycle t for the frame currently displaying dig/dps.
  task automatic check_cycle(input logic [15:0] dig, input logic [3:0] dps);
    int slot;
    int idx;
    logic [3:0] exp_digit;
    logic [3:0] exp_bcd;
    logic exp_dp;
    logic exp_frame;
    slot = t % 8;
    idx  = (t / 8) % 4;
    exp_digit = 4'b0000;
    if (!((t >= blank_lo) && (t <= blank_hi)) && (slot >= 2))
      exp_digit = 4'b0001 << idx;
    exp_bcd   = dig[idx*4 +: 4];
    exp_dp    = dps[idx];
    exp_frame = ((t % 32) == 0) && (t != 0);
    check_val("digit", {28'd0, o_digit}, {28'd0, exp_digit});
    check_val("bcd",   {28'd0, o_bcd},   {28'd0, exp_bcd});
    check_val("dp",    {31'd0, o_dp},    {31'd0, exp_dp});
    check_val("frame", {31'd0, o_frame}, {31'd0, exp_frame});
  endtask

  task automatic stim();
    if (stim_en) begin
      case (t)
        10:  begin i_digits = 16'h1234; i_dps = 4'b0100; i_load = 1'b1; end
        40:  begin i_digits = 16'hAAAA; i_dps = 4'b1111; i_load = 1'b1; end
        63:  begin i_digits = 16'h5555; i_dps = 4'b0000; i_load = 1'b1; end
        100: begin i_digits = 16'h1111; i_dps = 4'b0001; i_load = 1'b1; end
        110: begin i_digits = 16'hFE98; i_dps = 4'b1000; i_load = 1'b1; end
        163: i_blank = 1'b1;
        183: i_blank = 1'b0;
        195: begin i_digits = 16'h7777; i_dps = 4'b1111; i_load = 1'b1; end
        default: i_load = 1'b0;
      endcase
    end
  endtask

  task automatic run_cycles(input logic [15:0] dig, input logic [3:0] dps, input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle(dig, dps);
      stim();
      tick();
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_digits = 16'h0000;
    i_dps    = 4'b0000;
    i_load   = 1'b0;
    i_blank  = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;
    t     = 0;
    check_val("rst_digit", {28'd0, o_digit}, 32'd0);
    check_val("rst_bcd",   {28'd0, o_bcd},   32'd0);
    check_val("rst_dp",    {31'd0, o_dp},    32'd0);
    check_val("rst_frame", {31'd0, o_frame}, 32'd0);

    run_cycles(16'h0000, 4'b0000, 32);   // load 1234 mid-frame, not yet visible
    run_cycles(16'h1234, 4'b0100, 32);   // AAAA pending, 5555 loaded on commit edge
    run_cycles(16'hAAAA, 4'b1111, 32);
    run_cycles(16'h5555, 4'b0000, 32);   // two loads, only the last one shows
    run_cycles(16'hFE98, 4'b1000, 32);
    blank_lo = 164;
    blank_hi = 183;
    run_cycles(16'hFE98, 4'b1000, 32);
    blank_lo = 0;
    blank_hi = -1;
    run_cycles(16'hFE98, 4'b1000, 8);    // 7777 pending when reset hits

    stim_en = 1'b0;
    i_load  = 1'b0;
    i_rst   = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    t     = 0;
    check_val("mid_rst_digit", {28'd0, o_digit}, 32'd0);
    check_val("mid_rst_bcd",   {28'd0, o_bcd},   32'd0);
    check_val("mid_rst_dp",    {31'd0, o_dp},    32'd0);
    check_val("mid_rst_frame", {31'd0, o_frame}, 32'd0);
    run_cycles(16'h0000, 4'b0000, 32);
    run_cycles(16'h0000, 4'b0000, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
